// File: rtl/mips_multicycle_core_if.sv
// Unified instruction/data memory bus for mips_multicycle_core.
// master: the core (drives request, direction, address, store data).
// slave : the memory (returns read data and the ready handshake).
// A transfer completes on the rising edge where mem_req & mem_ready are both high.
interface mips_multicycle_core_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS core: control FSM, 32x32 register file, ALU and one unified memory port
// with a ready handshake, so memory may insert any number of wait states.
// Ports:
//   clk     - rising-edge clock
//   reset   - asynchronous active-low reset
//   mem     - unified memory bus (master side)
//   pc      - architectural PC
//   retire  - one-cycle pulse in the final state of each instruction
//   illegal - sticky flag, set when an unsupported instruction is decoded
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        reset,
    mips_multicycle_core_if.master      mem,
    output logic [31:0]                 pc,
    output logic                        retire,
    output logic                        illegal
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXEC   = 4'd6;
    localparam logic [3:0] ALUWB  = 4'd7;
    localparam logic [3:0] ADDIEX = 4'd8;
    localparam logic [3:0] ADDIWB = 4'd9;
    localparam logic [3:0] BRANCH = 4'd10;
    localparam logic [3:0] JUMP   = 4'd11;
    localparam logic [3:0] ERROR  = 4'd12;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2a;

    logic [3:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] aluout_q, aluout_d;
    logic        illegal_q, illegal_d;

    logic [31:0] rf [32];
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rs;
    logic [31:0] rf_rt;

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] signimm;
    logic        funct_ok;
    logic [31:0] alu_result;
    logic        handshake;
    logic        branch_taken;

    assign opcode  = ir_q[31:26];
    assign rs      = ir_q[25:21];
    assign rt      = ir_q[20:16];
    assign rd      = ir_q[15:11];
    assign shamt   = ir_q[10:6];
    assign funct   = ir_q[5:0];
    assign signimm = {{16{ir_q[15]}}, ir_q[15:0]};

    // Only the supported R-type functions are routed to EXEC; the rest trap.
    assign funct_ok = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                      (funct == F_OR)  || (funct == F_SLT) || (funct == F_SLL);

    // r0 is hard-wired to zero on the read side; writes to it are dropped below.
    assign rf_rs = (rs == 5'd0) ? 32'd0 : rf[rs];
    assign rf_rt = (rt == 5'd0) ? 32'd0 : rf[rt];

    // Request is gated by reset so it drops the instant reset asserts, even mid-transfer.
    assign mem.mem_req   = reset &&
                           ((state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR));
    assign mem.mem_we    = reset && (state_q == MEMWR);
    assign mem.mem_addr  = (state_q == FETCH) ? pc_q : aluout_q;
    assign mem.mem_wdata = b_q;

    assign handshake = mem.mem_req && mem.mem_ready;

    assign pc      = pc_q;
    assign illegal = illegal_q;

    // A store retires on its handshake cycle; every other instruction in its last state.
    assign retire = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == ADDIWB) ||
                    (state_q == BRANCH) || (state_q == JUMP) ||
                    ((state_q == MEMWR) && handshake);

    // bne inverts the equality test of beq.
    assign branch_taken = (a_q == b_q) ^ (opcode == OP_BNE);

    always_comb begin
        alu_result = 32'd0;
        case (funct)
            F_ADD:   alu_result = a_q + b_q;
            F_SUB:   alu_result = a_q - b_q;
            F_AND:   alu_result = a_q & b_q;
            F_OR:    alu_result = a_q | b_q;
            F_SLT:   alu_result = {31'd0, $signed(a_q) < $signed(b_q)};
            F_SLL:   alu_result = b_q << shamt;
            default: alu_result = 32'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        mdr_d     = mdr_q;
        a_d       = a_q;
        b_d       = b_q;
        aluout_d  = aluout_q;
        illegal_d = illegal_q;
        rf_we     = 1'b0;
        rf_waddr  = rt;
        rf_wdata  = aluout_q;

        case (state_q)
            FETCH: begin
                if (handshake) begin
                    ir_d    = mem.mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d = rf_rs;
                b_d = rf_rt;
                // pc already holds pc+4 here, so this is the branch target.
                aluout_d = pc_q + {signimm[29:0], 2'b00};
                case (opcode)
                    OP_LW, OP_SW:   state_d = MEMADR;
                    OP_R:           state_d = funct_ok ? EXEC : ERROR;
                    OP_ADDI:        state_d = ADDIEX;
                    OP_BEQ, OP_BNE: state_d = BRANCH;
                    OP_J:           state_d = JUMP;
                    default:        state_d = ERROR;
                endcase
            end
            MEMADR: begin
                aluout_d = a_q + signimm;
                state_d  = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                if (handshake) begin
                    mdr_d   = mem.mem_rdata;
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                rf_we    = 1'b1;
                rf_waddr = rt;
                rf_wdata = mdr_q;
                state_d  = FETCH;
            end
            MEMWR: begin
                if (handshake) begin
                    state_d = FETCH;
                end
            end
            EXEC: begin
                aluout_d = alu_result;
                state_d  = ALUWB;
            end
            ALUWB: begin
                rf_we    = 1'b1;
                rf_waddr = rd;
                rf_wdata = aluout_q;
                state_d  = FETCH;
            end
            ADDIEX: begin
                aluout_d = a_q + signimm;
                state_d  = ADDIWB;
            end
            ADDIWB: begin
                rf_we    = 1'b1;
                rf_waddr = rt;
                rf_wdata = aluout_q;
                state_d  = FETCH;
            end
            BRANCH: begin
                if (branch_taken) begin
                    pc_d = aluout_q;
                end
                state_d = FETCH;
            end
            JUMP: begin
                pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                state_d = FETCH;
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = ERROR;
            end
        endcase

        // Flag goes up on the edge that enters ERROR and stays until reset.
        if (state_d == ERROR) begin
            illegal_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'd0;
            mdr_q     <= 32'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            aluout_q  <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            aluout_q  <= aluout_d;
            illegal_q <= illegal_d;
        end
    end

    // Register file is deliberately not reset; state is FETCH during reset so no write fires.
    always_ff @(posedge clk) begin
        if (rf_we && (rf_waddr != 5'd0)) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed testbench for mips_multicycle_core: programs run from 0x100, data lives below 0x100.
module tb_mips_multicycle_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc;
    logic        retire;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    mips_multicycle_core_if bus ();

    mips_multicycle_core #(.RESET_PC(32'h0000_0100)) dut (
        .clk     (clk),
        .reset   (reset),
        .mem     (bus),
        .pc      (pc),
        .retire  (retire),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    // Memory model: imem (0x100..0x1FF) written only by the stimulus, dmem (0x00..0xFF)
    // written only by the bus. Data accesses wait stall_data cycles before ready.
    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    int          stall_data = 0;
    int          stall_cnt;
    int          wr_count;
    logic        data_region;

    assign data_region   = bus.mem_addr < 32'h100;
    assign bus.mem_ready = !data_region || (stall_cnt >= stall_data);
    assign bus.mem_rdata = data_region ? dmem[bus.mem_addr[7:2]] : imem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= 0;
            wr_count  <= 0;
            for (int i = 0; i < 64; i++) dmem[i] <= 32'd0;
        end else begin
            if (bus.mem_req && data_region) begin
                stall_cnt <= bus.mem_ready ? 0 : stall_cnt + 1;
            end
            if (bus.mem_req && bus.mem_we && bus.mem_ready) begin
                dmem[bus.mem_addr[7:2]] <= bus.mem_wdata;
                wr_count <= wr_count + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 32'd0; // sll r0,r0,0 acts as a nop
    endtask

    // Hold reset over an edge, release it just after an edge; returns at the sample
    // point of cycle 1 (first cycle after release).
    task automatic start();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
    endtask

    // Records retire for cycles 1..n; returns at the sample point of cycle n+1.
    task automatic run(input int n, output logic [63:0] rv);
        rv = '0;
        for (int k = 1; k <= n; k++) begin
            rv[k] = retire;
            step();
        end
    endtask

    task automatic test_reset();
        clear_imem();
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: req=%b we=%b required 0 0", bus.mem_req, bus.mem_we);
        end
        checks++;
        if (pc !== 32'h100 || retire !== 1'b0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pc=%h retire=%b illegal=%b required 100 0 0",
                     pc, retire, illegal);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL first_fetch: req=%b addr=%h required 1 100", bus.mem_req, bus.mem_addr);
        end
        step();
        checks++;
        if (pc !== 32'h104) begin
            errors++;
            $display("FAIL fetch_pc: pc=%h required 104", pc);
        end
    endtask

    task automatic test_alu();
        logic [63:0] rv;
        logic [63:0] exp;
        clear_imem();
        imem[0] = 32'h2001_0005; // addi r1,r0,5
        imem[1] = 32'h2002_FFFD; // addi r2,r0,-3
        imem[2] = 32'h0022_1820; // add  r3,r1,r2
        imem[3] = 32'h0041_202A; // slt  r4,r2,r1
        imem[4] = 32'h0001_2900; // sll  r5,r1,4
        start();
        run(20, rv);
        exp = '0;
        exp[4] = 1'b1; exp[8] = 1'b1; exp[12] = 1'b1; exp[16] = 1'b1; exp[20] = 1'b1;
        checks++;
        if (rv !== exp) begin
            errors++;
            $display("FAIL alu_retire: got %h required %h", rv, exp);
        end
        checks++;
        if (dut.rf[3] !== 32'd2 || dut.rf[4] !== 32'd1 || dut.rf[5] !== 32'd80) begin
            errors++;
            $display("FAIL alu_results: r3=%0d r4=%0d r5=%0d required 2 1 80",
                     dut.rf[3], dut.rf[4], dut.rf[5]);
        end
        checks++;
        if (pc !== 32'h114) begin
            errors++;
            $display("FAIL alu_pc: pc=%h required 114", pc);
        end
    endtask

    task automatic test_mem_wait();
        logic [63:0] rv;
        logic [63:0] exp;
        int held;
        clear_imem();
        imem[0] = 32'h2001_0005; // addi r1,r0,5
        imem[1] = 32'hAC01_0008; // sw   r1,8(r0)
        imem[2] = 32'h8C06_0008; // lw   r6,8(r0)
        stall_data = 2;
        start();
        rv = '0;
        held = 0;
        for (int k = 1; k <= 17; k++) begin
            rv[k] = retire;
            if (bus.mem_req && bus.mem_we && bus.mem_addr == 32'h8 && bus.mem_wdata == 32'd5)
                held++;
            step();
        end
        exp = '0;
        exp[4] = 1'b1; exp[10] = 1'b1; exp[17] = 1'b1;
        checks++;
        if (rv !== exp) begin
            errors++;
            $display("FAIL mem_retire: got %h required %h", rv, exp);
        end
        checks++;
        if (held !== 3) begin
            errors++;
            $display("FAIL store_held: %0d cycles required 3", held);
        end
        checks++;
        if (dmem[2] !== 32'd5 || wr_count !== 1) begin
            errors++;
            $display("FAIL store_data: mem[8]=%0d writes=%0d required 5 1", dmem[2], wr_count);
        end
        checks++;
        if (dut.rf[6] !== 32'd5) begin
            errors++;
            $display("FAIL load_data: r6=%0d required 5", dut.rf[6]);
        end
        stall_data = 0;
    endtask

    task automatic test_beq_loop();
        logic [63:0] rv;
        logic [63:0] exp;
        logic [31:0] a8;
        logic [31:0] a11;
        clear_imem();
        imem[0] = 32'h2001_0005; // addi r1,r0,5
        imem[1] = 32'h1021_FFFF; // beq  r1,r1,-1
        start();
        rv = '0;
        a8 = '0;
        a11 = '0;
        for (int k = 1; k <= 11; k++) begin
            rv[k] = retire;
            if (k == 8) a8 = bus.mem_addr;
            if (k == 11) a11 = bus.mem_addr;
            step();
        end
        exp = '0;
        exp[4] = 1'b1; exp[7] = 1'b1; exp[10] = 1'b1;
        checks++;
        if (rv !== exp) begin
            errors++;
            $display("FAIL beq_retire: got %h required %h", rv, exp);
        end
        checks++;
        if (a8 !== 32'h104 || a11 !== 32'h104) begin
            errors++;
            $display("FAIL beq_target: fetch %h %h required 104 104", a8, a11);
        end
    endtask

    task automatic test_bne_jump();
        logic [31:0] a8;
        logic [31:0] pc10;
        logic [31:0] a11;
        logic [31:0] pc11;
        clear_imem();
        imem[0] = 32'h2001_0005; // addi r1,r0,5
        imem[1] = 32'h1421_0004; // bne  r1,r1,+4
        imem[2] = 32'h0800_0040; // j    0x40
        start();
        a8 = '0; pc10 = '0; a11 = '0; pc11 = '0;
        for (int k = 1; k <= 11; k++) begin
            if (k == 8) a8 = bus.mem_addr;
            if (k == 10) pc10 = pc;
            if (k == 11) begin
                a11 = bus.mem_addr;
                pc11 = pc;
            end
            step();
        end
        checks++;
        if (a8 !== 32'h108) begin
            errors++;
            $display("FAIL bne_fallthrough: fetch %h required 108", a8);
        end
        checks++;
        if (pc10 !== 32'h10C) begin
            errors++;
            $display("FAIL jump_pc4: pc=%h required 10c", pc10);
        end
        checks++;
        if (a11 !== 32'h100 || pc11 !== 32'h100) begin
            errors++;
            $display("FAIL jump_target: addr=%h pc=%h required 100 100", a11, pc11);
        end
    endtask

    task automatic test_r0();
        logic [63:0] rv;
        clear_imem();
        imem[0] = 32'h2007_0009; // addi r7,r0,9
        imem[1] = 32'h2000_0007; // addi r0,r0,7
        imem[2] = 32'h0000_3820; // add  r7,r0,r0
        start();
        run(12, rv);
        checks++;
        if (dut.rf[7] !== 32'd0) begin
            errors++;
            $display("FAIL r0_zero: r7=%0d required 0", dut.rf[7]);
        end
    endtask

    task automatic test_illegal();
        logic ill2;
        int   ill_cnt;
        int   req_cnt;
        logic [31:0] pc8;
        clear_imem();
        imem[0] = 32'hFC00_0000; // opcode 6'b111111
        start();
        ill2 = 1'b1;
        ill_cnt = 0;
        req_cnt = 0;
        pc8 = '0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 2) ill2 = illegal;
            if (k >= 4 && illegal === 1'b1) ill_cnt++;
            if (k >= 3 && bus.mem_req !== 1'b0) req_cnt++;
            if (k == 8) pc8 = pc;
            step();
        end
        checks++;
        if (ill2 !== 1'b0 || ill_cnt !== 5) begin
            errors++;
            $display("FAIL illegal_flag: decode=%b sticky_cycles=%0d required 0 5", ill2, ill_cnt);
        end
        checks++;
        if (req_cnt !== 0 || pc8 !== 32'h104) begin
            errors++;
            $display("FAIL illegal_frozen: req_cycles=%0d pc=%h required 0 104", req_cnt, pc8);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (illegal !== 1'b0 || pc !== 32'h100 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL illegal_reset: illegal=%b pc=%h req=%b required 0 100 0",
                     illegal, pc, bus.mem_req);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL illegal_restart: req=%b addr=%h required 1 100",
                     bus.mem_req, bus.mem_addr);
        end
    endtask

    initial begin
        clear_imem();
        test_reset();
        test_alu();
        test_mem_wait();
        test_beq_loop();
        test_bne_jump();
        test_r0();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
